// File: rtl/ballot_if.sv
// Booth-side and readout-side signal bundle for ballot_arbiter.
// master drives session pulses and booth requests; slave is the arbiter.
interface ballot_if #(
   parameter int NUM_BOOTHS = 4,
   parameter int CNT_W      = 32
);
   logic                    i_session_open;
   logic                    i_session_close;
   logic [NUM_BOOTHS-1:0]   i_vote_req;
   logic [2*NUM_BOOTHS-1:0] i_vote_cand;
   logic [NUM_BOOTHS-1:0]   o_vote_ack;
   logic [NUM_BOOTHS-1:0]   o_booth_busy;
   logic [1:0]              o_state;
   logic                    o_results_valid;
   logic [CNT_W-1:0]        o_count1;
   logic [CNT_W-1:0]        o_count2;
   logic [CNT_W-1:0]        o_count3;
   logic [CNT_W-1:0]        o_spoiled;
   logic [CNT_W-1:0]        o_total;

   modport master (
      output i_session_open, i_session_close, i_vote_req, i_vote_cand,
      input  o_vote_ack, o_booth_busy, o_state, o_results_valid,
      input  o_count1, o_count2, o_count3, o_spoiled, o_total
   );

   modport slave (
      input  i_session_open, i_session_close, i_vote_req, i_vote_cand,
      output o_vote_ack, o_booth_busy, o_state, o_results_valid,
      output o_count1, o_count2, o_count3, o_spoiled, o_total
   );
endinterface

// File: rtl/ballot_arbiter.sv
// Voting session controller: round-robin grants of booth votes into saturating tallies, per-booth lockout.
// Latency: request sampled at an edge is acked the following cycle; ungranted requests wait (held level).
// Backpressure: booths in lockout or outside OPEN are not granted. Optional BALLOT_AUDIT_EN adds vote audit.
module ballot_arbiter #(
   parameter int NUM_BOOTHS  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 32
) (
   input logic     clk,
   input logic     rst,
   ballot_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_BOOTHS);
   localparam int TMR_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      OPEN    = 2'b01,
      CLOSING = 2'b10,
      DONE    = 2'b11
   } state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      ptr;
   logic [NUM_BOOTHS-1:0] ack;
   logic [NUM_BOOTHS-1:0] busy;
   logic [NUM_BOOTHS-1:0] eligible;
   logic [TMR_W-1:0]      timer [NUM_BOOTHS];

   logic                  grant_en, clr_tally, clr_pub, latch_pub;
   logic                  gnt_any, gnt_vld;
   logic [IDX_W-1:0]      gnt_idx;
   logic [1:0]            gnt_cand;

   logic [CNT_W-1:0]      tally1, tally2, tally3, tally_sp;
   logic [CNT_W-1:0]      pub1, pub2, pub3, pub_sp;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      for (int b = 0; b < NUM_BOOTHS; b++) begin
         busy[b] = (timer[b] != '0);
      end
   end

   assign eligible = bus.i_vote_req & ~busy;

   // First eligible booth searching upward from the pointer, with wrap.
   always_comb begin
      int b;
      b        = 0;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_cand = 2'd0;
      for (int i = 0; i < NUM_BOOTHS; i++) begin
         b = (int'(ptr) + i) % NUM_BOOTHS;
         if (!gnt_any && eligible[b]) begin
            gnt_any  = 1'b1;
            gnt_idx  = IDX_W'(b);
            gnt_cand = bus.i_vote_cand[2*b +: 2];
         end
      end
   end

   assign gnt_vld = gnt_any && grant_en;

   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      clr_tally = 1'b0;
      clr_pub   = 1'b0;
      latch_pub = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_session_open) begin
               state_nxt = OPEN;
               clr_tally = 1'b1;
            end
         end
         OPEN: begin
            // Close takes priority and suppresses the grant in the same cycle.
            if (bus.i_session_close) state_nxt = CLOSING;
            else                     grant_en  = 1'b1;
         end
         CLOSING: begin
            if (busy == '0) begin
               state_nxt = DONE;
               latch_pub = 1'b1;
            end
         end
         DONE: begin
            if (bus.i_session_open) begin
               state_nxt = OPEN;
               clr_tally = 1'b1;
               clr_pub   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         ack   <= '0;
         for (int b = 0; b < NUM_BOOTHS; b++) timer[b] <= '0;
      end else begin
         state <= state_nxt;
         ack   <= '0;
         for (int b = 0; b < NUM_BOOTHS; b++) begin
            if (timer[b] != '0) timer[b] <= timer[b] - TMR_W'(1);
         end
         if (gnt_vld) begin
            ack[gnt_idx]   <= 1'b1;
            timer[gnt_idx] <= TMR_W'(HOLD_CYCLES);
            ptr            <= (gnt_idx == IDX_W'(NUM_BOOTHS - 1)) ? '0 : gnt_idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tally1   <= '0;
         tally2   <= '0;
         tally3   <= '0;
         tally_sp <= '0;
         pub1     <= '0;
         pub2     <= '0;
         pub3     <= '0;
         pub_sp   <= '0;
      end else begin
         if (clr_tally) begin
            tally1   <= '0;
            tally2   <= '0;
            tally3   <= '0;
            tally_sp <= '0;
         end else if (gnt_vld) begin
            case (gnt_cand)
               2'd1:    tally1   <= sat_inc(tally1);
               2'd2:    tally2   <= sat_inc(tally2);
               2'd3:    tally3   <= sat_inc(tally3);
               default: tally_sp <= sat_inc(tally_sp);
            endcase
         end
         if (clr_pub) begin
            pub1   <= '0;
            pub2   <= '0;
            pub3   <= '0;
            pub_sp <= '0;
         end else if (latch_pub) begin
            pub1   <= tally1;
            pub2   <= tally2;
            pub3   <= tally3;
            pub_sp <= tally_sp;
         end
      end
   end

`ifdef BALLOT_AUDIT_EN
   logic [CNT_W-1:0] audit_cnt, pub_total;
   logic [CNT_W+1:0] audit_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         audit_cnt <= '0;
         pub_total <= '0;
      end else begin
         if (clr_tally)    audit_cnt <= '0;
         else if (gnt_vld) audit_cnt <= sat_inc(audit_cnt);
         if (clr_pub)        pub_total <= '0;
         else if (latch_pub) pub_total <= audit_cnt;
      end
   end

   assign audit_sum = (CNT_W+2)'(tally1) + (CNT_W+2)'(tally2)
                    + (CNT_W+2)'(tally3) + (CNT_W+2)'(tally_sp);

   // Every ack lands in exactly one tally unless some counter has clipped.
   always_ff @(posedge clk) begin
      if (!rst && !(&tally1) && !(&tally2) && !(&tally3) && !(&tally_sp) && !(&audit_cnt))
         assert (audit_sum == (CNT_W+2)'(audit_cnt));
   end

   assign bus.o_total = pub_total;
`else
   assign bus.o_total = '0;
`endif

   assign bus.o_vote_ack      = ack;
   assign bus.o_booth_busy    = busy;
   assign bus.o_state         = state;
   assign bus.o_results_valid = (state == DONE);
   assign bus.o_count1        = pub1;
   assign bus.o_count2        = pub2;
   assign bus.o_count3        = pub3;
   assign bus.o_spoiled       = pub_sp;
endmodule

// File: tb/tb_ballot_arbiter.sv
// Scoreboard bench for ballot_arbiter: expected ack order queued at drive time, popped on each ack.
module tb_ballot_arbiter;
   localparam int NB   = 4;
   localparam int HOLD = 16;
   localparam int CW   = 32;
`ifdef BALLOT_AUDIT_EN
   localparam bit AUDIT = 1'b1;
`else
   localparam bit AUDIT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   last_ack_cyc = 0;
   int   exp_q[$];

   always #5 clk = ~clk;

   ballot_if #(.NUM_BOOTHS(NB), .CNT_W(CW)) bus ();

   ballot_arbiter #(.NUM_BOOTHS(NB), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock; sample after the edge, score any ack and release the acked request.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_vote_ack != '0) begin
         last_ack_cyc = cyc;
         if (exp_q.size() == 0) check("unexpected_ack", 64'(bus.o_vote_ack), 64'd0);
         else                   check("ack_booth", 64'(bus.o_vote_ack), 64'(1) << exp_q.pop_front());
         bus.i_vote_req = bus.i_vote_req & ~bus.o_vote_ack;
      end
   endtask

   task automatic wait_acks(input int max);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max) begin
         step();
         n++;
      end
      check("acks_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic wait_state(input logic [1:0] target, input int max);
      int n;
      n = 0;
      while (bus.o_state != target && n < max) begin
         step();
         n++;
      end
      check("state_reached", 64'(bus.o_state), 64'(target));
   endtask

   task automatic pulse_open();
      bus.i_session_open = 1'b1;
      step();
      bus.i_session_open = 1'b0;
   endtask

   task automatic pulse_close();
      bus.i_session_close = 1'b1;
      step();
      bus.i_session_close = 1'b0;
   endtask

   task automatic check_pub(input string tag, input int c1, input int c2, input int c3,
                            input int sp, input int tot);
      check({tag, "_count1"},  64'(bus.o_count1),  64'(c1));
      check({tag, "_count2"},  64'(bus.o_count2),  64'(c2));
      check({tag, "_count3"},  64'(bus.o_count3),  64'(c3));
      check({tag, "_spoiled"}, 64'(bus.o_spoiled), 64'(sp));
      check({tag, "_total"},   64'(bus.o_total),   64'(tot));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t1;
      int c;
      rst = 1'b1;
      bus.i_session_open  = 1'b0;
      bus.i_session_close = 1'b0;
      bus.i_vote_req      = '0;
      bus.i_vote_cand     = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_state", 64'(bus.o_state), 64'd0);
      check("rst_ack", 64'(bus.o_vote_ack), 64'd0);
      check("rst_busy", 64'(bus.o_booth_busy), 64'd0);
      check("rst_valid", 64'(bus.o_results_valid), 64'd0);
      check_pub("rst", 0, 0, 0, 0, 0);

      // Close in IDLE is ignored.
      pulse_close();
      check("idle_close_ignored", 64'(bus.o_state), 64'd0);

      // Session 1: four simultaneous requests, then a re-request inside lockout.
      pulse_open();
      check("open_state", 64'(bus.o_state), 64'd1);
      bus.i_vote_cand = {2'd0, 2'd3, 2'd2, 2'd1};
      bus.i_vote_req  = 4'hF;
      exp_q = '{0, 1, 2, 3};
      t1 = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 1) begin
            t1 = last_ack_cyc;
            bus.i_vote_req[1] = 1'b1;
         end
      end
      check("rr_consecutive", 64'(exp_q.size()), 64'd0);
      exp_q.push_back(1);
      wait_acks(40);
      check("lockout_gap", 64'(last_ack_cyc - t1), 64'(HOLD + 1));
      pulse_close();
      check("closing_state", 64'(bus.o_state), 64'd2);
      check("stale_count2", 64'(bus.o_count2), 64'd0);
      wait_state(2'd3, 40);
      check("done_valid", 64'(bus.o_results_valid), 64'd1);
      check_pub("s1", 1, 2, 1, 1, AUDIT ? 5 : 0);

      // Session 2: single-vote latency, lockout length, close while a booth drains.
      pulse_open();
      check("reopen_state", 64'(bus.o_state), 64'd1);
      check("reopen_valid", 64'(bus.o_results_valid), 64'd0);
      check_pub("reopen", 0, 0, 0, 0, 0);
      bus.i_vote_cand = {2'd0, 2'd3, 2'd0, 2'd2};
      bus.i_vote_req  = 4'b0001;
      exp_q.push_back(0);
      step();
      check("ack_latency", 64'(exp_q.size()), 64'd0);
      n = 0;
      while (bus.o_booth_busy[0] && n < 40) begin
         n++;
         step();
      end
      check("busy_len", 64'(n), 64'(HOLD));
      bus.i_vote_req[2] = 1'b1;
      exp_q.push_back(2);
      step();
      check("ack_booth2", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < HOLD - 5; i++) step();
      bus.i_vote_req[3]   = 1'b1;
      bus.i_session_close = 1'b1;
      step();
      bus.i_session_close = 1'b0;
      n = 0;
      while (bus.o_state == 2'd2 && n < 40) begin
         n++;
         step();
      end
      check("closing_len", 64'(n), 64'd5);
      check("done_state", 64'(bus.o_state), 64'd3);
      bus.i_vote_req = '0;
      check_pub("s2", 0, 1, 1, 0, AUDIT ? 2 : 0);

      // Session 3: open and close together while OPEN.
      pulse_open();
      bus.i_vote_req      = 4'b0001;
      bus.i_session_open  = 1'b1;
      bus.i_session_close = 1'b1;
      step();
      bus.i_session_open  = 1'b0;
      bus.i_session_close = 1'b0;
      check("open_close_state", 64'(bus.o_state), 64'd2);
      check("open_close_no_ack", 64'(bus.o_vote_ack), 64'd0);
      bus.i_vote_req = '0;
      wait_state(2'd3, 10);
      check_pub("s3", 0, 0, 0, 0, 0);

      // Session 4: reset mid-session, then the pointer must restart at booth 0.
      pulse_open();
      bus.i_vote_cand = {2'd0, 2'd1, 2'd1, 2'd1};
      bus.i_vote_req  = 4'b0111;
      exp_q = '{0, 1, 2};
      wait_acks(10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_state", 64'(bus.o_state), 64'd0);
      check("midrst_busy", 64'(bus.o_booth_busy), 64'd0);
      check("midrst_ack", 64'(bus.o_vote_ack), 64'd0);
      check_pub("midrst", 0, 0, 0, 0, 0);
      pulse_open();
      bus.i_vote_cand = {2'd0, 2'd0, 2'd0, 2'd1};
      bus.i_vote_req  = 4'b1001;
      exp_q = '{0, 3};
      wait_acks(10);
      pulse_close();
      wait_state(2'd3, 40);
      c = AUDIT ? 2 : 0;
      check_pub("s4", 1, 0, 0, 1, c);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ballot_arbiter.md
Name: ballot_arbiter

Overview:
- Session controller and round-robin arbiter that shares one vote tally datapath among NUM_BOOTHS voting booths.
- Opens and closes a voting session and grants at most one booth vote per cycle into three candidate counters.
- Applies a per-booth lockout after each accepted vote and publishes frozen results when the session ends.
- Sits between the booth input front-ends and the results display/readout logic.

Parameters:
- NUM_BOOTHS, 4, number of requesting booths (2..8)
- HOLD_CYCLES, 16, lockout length in cycles after a booth's vote is accepted (1..255)
- CNT_W, 32, width of every tally counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_session_open  in  1  single-cycle pulse: clear tallies, start a session
- i_session_close  in  1  single-cycle pulse: stop accepting votes
- i_vote_req  in  NUM_BOOTHS  per-booth vote request (level, held until ack)
- i_vote_cand  in  2*NUM_BOOTHS  per-booth candidate code; booth b uses bits [2b+1:2b]; 1/2/3 = candidate, 0 = spoiled
- o_vote_ack  out  NUM_BOOTHS  one-hot, one-cycle acceptance pulse
- o_booth_busy  out  NUM_BOOTHS  booth is in lockout
- o_state  out  2  00 IDLE, 01 OPEN, 10 CLOSING, 11 DONE
- o_results_valid  out  1  high in DONE
- o_count1, o_count2, o_count3  out  CNT_W  published candidate tallies
- o_spoiled  out  CNT_W  published spoiled-ballot tally
- o_total  out  CNT_W  audit count of accepted votes (see Optional Feature)

Behaviour:
- Reset, evaluated at the clk edge:
  - State goes to IDLE.
  - All internal tallies, o_count*, o_spoiled, o_total, o_vote_ack, o_booth_busy, lockout timers and o_results_valid go to 0.
  - Round-robin pointer goes to 0, so booth 0 has highest priority.
  - Reset overrides every other input in the same cycle, including mid-session; in-flight acks are dropped.
- IDLE:
  - i_session_open takes the block to OPEN at the next edge and clears the internal tallies.
  - i_session_close is ignored.
- OPEN:
  - Eligible booth = i_vote_req high and o_booth_busy low.
  - Among eligible booths, grant the first one found searching upward (with wrap) from the pointer.
  - At the grant edge:
    - The matching tally increments: code 1/2/3 increments candidate 1/2/3; code 0 increments spoiled.
    - o_vote_ack[b] is high for exactly the following cycle.
    - o_booth_busy[b] rises and stays high for exactly HOLD_CYCLES cycles.
    - The pointer moves to b+1 mod NUM_BOOTHS.
  - Latency: a request sampled at edge k gives the ack in cycle k..k+1; an ungranted request waits.
  - Throughput: one vote per cycle maximum.
  - With N eligible booths, every booth is granted within N cycles.
  - i_session_close moves the block to CLOSING at the next edge and blocks any grant in that cycle. If open and close arrive together, close wins.
  - i_session_open while OPEN is ignored.
- CLOSING:
  - No grants are made.
  - Lockout timers keep running.
  - When o_booth_busy is all zero, go to DONE and latch internal tallies into o_count1..3, o_spoiled and o_total in that same edge.
- DONE:
  - o_results_valid = 1 and outputs hold.
  - i_session_open clears the internal tallies and all o_count*, o_spoiled and o_total, drops o_results_valid, and goes to OPEN.
- Published outputs change only on the DONE entry latch, on session-open from DONE, and on reset. They are stale (previous session) while OPEN or CLOSING.
- Arithmetic: tallies are CNT_W unsigned and saturate at all-ones. A vote accepted at saturation is still acked; the tally stays at its maximum.
- Requests, including a request dropped before ack, have no effect outside OPEN.
- An undefined state encoding is impossible; any illegal value returns to IDLE.

Optional Feature:
- Macro: BALLOT_AUDIT_EN
- When defined:
  - An internal counter counts every o_vote_ack pulse; it saturates and is cleared with the tallies.
  - o_total publishes that counter at DONE entry.
  - An internal check asserts in simulation that count1+count2+count3+spoiled == total when no counter is saturated.
- When not defined: the counter and check are absent and o_total is tied to 0.

Test Plan:
- Reset, then session_open. Booth 0 requests candidate 2 at cycle 3. Expected: ack[0] one cycle later, busy[0] high 16 cycles, internal tally2 = 1.
- All 4 booths request together with candidates 1,2,3,0. Expected: acks in order 0,1,2,3 on consecutive cycles. After close and lockout drain: count1=1, count2=1, count3=1, spoiled=1, o_total=4 with BALLOT_AUDIT_EN, 0 without.
- Booth 1 requests again during its lockout. Expected: no ack until cycle HOLD_CYCLES after the first ack, then ack and count +1.
- Close with booth 2 busy for 5 more cycles. Expected: state CLOSING for 5 cycles with no grants despite requests, then DONE, results_valid=1, outputs latched.
- session_open and session_close in the same OPEN cycle. Expected: CLOSING, no grant that cycle.
- rst mid-OPEN with 3 votes tallied. Expected: next cycle IDLE, all outputs 0, pointer 0. A subsequent open then 1 vote on candidate 1, then close, gives count1 = 1.
